// File: rtl/axil_master_port_if.sv
// Local command/response handshake plus the AXI4-Lite master channels.
interface axil_master_port_if #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = 4;

  // local command / response
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic                          cmd_write;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_W-1:0]             cmd_wstrb;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]                    rsp_resp;
  logic                          rsp_was_write;

  // AXI4-Lite write channels
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]                    M_AXI_AWPROT;
  logic                          M_AXI_AWVALID;
  logic                          M_AXI_AWREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [STRB_W-1:0]             M_AXI_WSTRB;
  logic                          M_AXI_WVALID;
  logic                          M_AXI_WREADY;
  logic [1:0]                    M_AXI_BRESP;
  logic                          M_AXI_BVALID;
  logic                          M_AXI_BREADY;

  // AXI4-Lite read channels
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]                    M_AXI_ARPROT;
  logic                          M_AXI_ARVALID;
  logic                          M_AXI_ARREADY;
  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]                    M_AXI_RRESP;
  logic                          M_AXI_RVALID;
  logic                          M_AXI_RREADY;

  // Initiator view
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_was_write,
    input  rsp_ready,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  // Command source, response sink and AXI slave view
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_was_write,
    output rsp_ready,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axil_master_port.sv
// Single-outstanding AXI4-Lite initiator driven by a local cmd/rsp handshake.
// Data width must be 32; the interface instance must use the same parameters.
module axil_master_port #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
  input logic           M_AXI_ACLK,
  input logic           M_AXI_ARESETN,
  axil_master_port_if.master bus
);
  localparam int unsigned ADDR_W = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DATA_W = C_M_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                rsp_was_write_q, rsp_was_write_d;
  logic                cmd_ready_c;

  // Commands are only taken while idle; this is the one combinational output.
  assign cmd_ready_c = (state_q == IDLE);

  // Next-state and next-output decode.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    awvalid_d       = awvalid_q;
    wvalid_d        = wvalid_q;
    bready_d        = bready_q;
    arvalid_d       = arvalid_q;
    rready_d        = rready_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_resp_d      = rsp_resp_q;
    rsp_was_write_d = rsp_was_write_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          if (bus.cmd_write) begin
            wdata_d   = bus.cmd_wdata;
            wstrb_d   = bus.cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        // AW and W retire independently; B is awaited once both are gone.
        if (bus.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (bus.M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end
      end
      WR_B: begin
        if (bus.M_AXI_BVALID) begin
          bready_d        = 1'b0;
          rsp_valid_d     = 1'b1;
          rsp_rdata_d     = '0;
          rsp_resp_d      = bus.M_AXI_BRESP;
          rsp_was_write_d = 1'b1;
          state_d         = RSP;
        end
      end
      RD_AR: begin
        if (bus.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (bus.M_AXI_RVALID) begin
          rready_d        = 1'b0;
          rsp_valid_d     = 1'b1;
          rsp_rdata_d     = bus.M_AXI_RDATA;
          rsp_resp_d      = bus.M_AXI_RRESP;
          rsp_was_write_d = 1'b0;
          state_d         = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      awvalid_q       <= 1'b0;
      wvalid_q        <= 1'b0;
      bready_q        <= 1'b0;
      arvalid_q       <= 1'b0;
      rready_q        <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_resp_q      <= '0;
      rsp_was_write_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      awvalid_q       <= awvalid_d;
      wvalid_q        <= wvalid_d;
      bready_q        <= bready_d;
      arvalid_q       <= arvalid_d;
      rready_q        <= rready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_resp_q      <= rsp_resp_d;
      rsp_was_write_q <= rsp_was_write_d;
    end
  end

  // Output mapping; one address register serves both AW and AR.
  assign bus.cmd_ready     = cmd_ready_c;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_resp      = rsp_resp_q;
  assign bus.rsp_was_write = rsp_was_write_q;
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_BREADY  = bready_q;
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axil_master_port.sv
// Bench for axil_master_port: stub AXI-Lite slave with programmable delays and
// responses, plus a word-array reference model of the expected responses.
module tb_axil_master_port;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axil_master_port_if #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) bus ();

  axil_master_port #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .bus          (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // slave configuration, set by the main sequence
  int          s_aw_dly = 0, s_w_dly = 0, s_b_dly = 0, s_ar_dly = 0, s_r_dly = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  bit          s_force_en = 1'b0;
  logic [31:0] s_force_data = 32'h0;

  // slave observations (written only by the slave process)
  int          cyc = 0, n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int          n_bready_pulse = 0, stab_err = 0, t_aw = 0, t_w = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  // reference model storage: four 32-bit words at byte addresses 0x0..0xC
  logic [31:0] ref_mem [4];

  // Stub AXI-Lite slave, evaluated on the falling edge.
  initial begin
    logic [31:0] s_mem [4];
    logic [31:0] mask;
    bit got_aw, got_w, got_ar, hs_aw, hs_w, hs_ar, hs_b, hs_r;
    bit p_awv, p_wv, p_arv, p_bready, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    for (int i = 0; i < 4; i++) s_mem[i] = 32'h0;
    got_aw = 0; got_w = 0; got_ar = 0;
    p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    cap_awaddr = 0; cap_wdata = 0; cap_araddr = 0; cap_wstrb = 0;
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
    bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
    bus.M_AXI_RVALID = 0; bus.M_AXI_RRESP = 0; bus.M_AXI_RDATA = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
        bus.M_AXI_BVALID = 0; bus.M_AXI_RVALID = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        continue;
      end
      hs_aw = p_awv && bus.M_AXI_AWREADY;
      hs_w  = p_wv && bus.M_AXI_WREADY;
      hs_ar = p_arv && bus.M_AXI_ARREADY;
      hs_b  = p_bready && bus.M_AXI_BVALID;
      hs_r  = p_rready && bus.M_AXI_RVALID;
      if (p_awv && !hs_aw && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR != p_awaddr)) stab_err++;
      if (p_wv && !hs_w && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA != p_wdata ||
                            bus.M_AXI_WSTRB != p_wstrb)) stab_err++;
      if (p_arv && !hs_ar && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR != p_araddr)) stab_err++;
      if (bus.M_AXI_BREADY && !p_bready) n_bready_pulse++;
      if (hs_aw) begin got_aw = 1; cap_awaddr = p_awaddr; n_aw++; t_aw = cyc; aw_cnt = 0; end
      if (hs_w) begin
        got_w = 1; cap_wdata = p_wdata; cap_wstrb = p_wstrb; n_w++; t_w = cyc; w_cnt = 0;
      end
      if (hs_ar) begin got_ar = 1; cap_araddr = p_araddr; n_ar++; ar_cnt = 0; end
      if (hs_b) begin bus.M_AXI_BVALID = 0; n_b++; end
      if (hs_r) begin bus.M_AXI_RVALID = 0; n_r++; end

      bus.M_AXI_AWREADY = 0;
      if (bus.M_AXI_AWVALID) begin
        if (aw_cnt >= s_aw_dly) bus.M_AXI_AWREADY = 1; else aw_cnt++;
      end
      bus.M_AXI_WREADY = 0;
      if (bus.M_AXI_WVALID) begin
        if (w_cnt >= s_w_dly) bus.M_AXI_WREADY = 1; else w_cnt++;
      end
      bus.M_AXI_ARREADY = 0;
      if (bus.M_AXI_ARVALID) begin
        if (ar_cnt >= s_ar_dly) bus.M_AXI_ARREADY = 1; else ar_cnt++;
      end
      if (got_aw && got_w && !bus.M_AXI_BVALID) begin
        if (b_cnt >= s_b_dly) begin
          bus.M_AXI_BVALID = 1;
          bus.M_AXI_BRESP  = s_bresp;
          if (s_bresp == 2'b00) begin
            mask = {{8{cap_wstrb[3]}}, {8{cap_wstrb[2]}}, {8{cap_wstrb[1]}}, {8{cap_wstrb[0]}}};
            s_mem[cap_awaddr[3:2]] = (s_mem[cap_awaddr[3:2]] & ~mask) | (cap_wdata & mask);
          end
          got_aw = 0; got_w = 0; b_cnt = 0;
        end else b_cnt++;
      end
      if (got_ar && !bus.M_AXI_RVALID) begin
        if (r_cnt >= s_r_dly) begin
          bus.M_AXI_RVALID = 1;
          bus.M_AXI_RRESP  = s_rresp;
          bus.M_AXI_RDATA  = s_force_en ? s_force_data : s_mem[cap_araddr[3:2]];
          got_ar = 0; r_cnt = 0;
        end else r_cnt++;
      end

      p_awv = bus.M_AXI_AWVALID; p_awaddr = bus.M_AXI_AWADDR;
      p_wv = bus.M_AXI_WVALID; p_wdata = bus.M_AXI_WDATA; p_wstrb = bus.M_AXI_WSTRB;
      p_arv = bus.M_AXI_ARVALID; p_araddr = bus.M_AXI_ARADDR;
      p_bready = bus.M_AXI_BREADY; p_rready = bus.M_AXI_RREADY;
    end
  end

  // One command/response round trip, called on a falling edge.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int hold, input bit chk_lat);
    int lat;
    int b_aw, b_w, b_b, b_ar, b_r, b_bp, b_st;
    logic [31:0] exp_rdata, s_rd;
    logic [1:0]  exp_resp, s_rs;
    logic        s_ww;
    bit          rsp_chg, crdy_bad;
    b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar; b_r = n_r;
    b_bp = n_bready_pulse; b_st = stab_err;
    rsp_chg = 0; crdy_bad = 0;
    if (wr) begin
      exp_resp = s_bresp; exp_rdata = 32'h0;
      if (s_bresp == 2'b00)
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[addr[3:2]][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      exp_resp  = s_rresp;
      exp_rdata = s_force_en ? s_force_data : ref_mem[addr[3:2]];
    end

    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = wdata; bus.cmd_wstrb = strb;
    lat = 0;
    while (!bus.cmd_ready && lat < 100) begin @(negedge clk); lat++; end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", 64'(0), 64'(1));
      bus.cmd_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // keep a different command pending; it must be ignored until idle
    bus.cmd_write = ~wr; bus.cmd_addr = addr ^ 32'h4; bus.cmd_wdata = ~wdata;
    lat = 1;
    while (!bus.rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!bus.rsp_valid) begin
      check("rsp_timeout", 64'(0), 64'(1));
      bus.cmd_valid = 0;
      return;
    end
    if (chk_lat) check("latency", 64'(lat), 64'(3));
    s_rd = bus.rsp_rdata; s_rs = bus.rsp_resp; s_ww = bus.rsp_was_write;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_rdata != s_rd || bus.rsp_resp != s_rs ||
          bus.rsp_was_write != s_ww) rsp_chg = 1;
      if (bus.cmd_ready) crdy_bad = 1;
    end
    bus.rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 0;
    bus.cmd_valid = 0;
    check("rsp_resp", 64'(s_rs), 64'(exp_resp));
    check("rsp_rdata", 64'(s_rd), 64'(exp_rdata));
    check("rsp_was_write", 64'(s_ww), 64'(wr));
    if (hold > 0) begin
      check("rsp_stable", 64'(rsp_chg), 64'(0));
      check("cmd_ready_busy", 64'(crdy_bad), 64'(0));
    end
    check("rsp_valid_drop", 64'(bus.rsp_valid), 64'(0));
    check("cmd_ready_idle", 64'(bus.cmd_ready), 64'(1));
    check("n_aw", 64'(n_aw - b_aw), 64'(wr ? 1 : 0));
    check("n_w", 64'(n_w - b_w), 64'(wr ? 1 : 0));
    check("n_b", 64'(n_b - b_b), 64'(wr ? 1 : 0));
    check("n_bready_pulse", 64'(n_bready_pulse - b_bp), 64'(wr ? 1 : 0));
    check("n_ar", 64'(n_ar - b_ar), 64'(wr ? 0 : 1));
    check("n_r", 64'(n_r - b_r), 64'(wr ? 0 : 1));
    check("axi_stability", 64'(stab_err - b_st), 64'(0));
    if (wr) begin
      check("awaddr", 64'(cap_awaddr), 64'(addr));
      check("wdata", 64'(cap_wdata), 64'(wdata));
      check("wstrb", 64'(cap_wstrb), 64'(strb));
    end else begin
      check("araddr", 64'(cap_araddr), 64'(addr));
    end
  endtask

  task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
    s_aw_dly = aw; s_w_dly = w; s_b_dly = b; s_ar_dly = ar; s_r_dly = r;
  endtask

  // Main sequence: directed scenarios, then randomized traffic.
  initial begin
    for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
    rst_n = 0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0;
    bus.cmd_wdata = 0; bus.cmd_wstrb = 0; bus.rsp_ready = 0;
    #1;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("rst_awvalid", 64'(bus.M_AXI_AWVALID), 64'(0));
    check("rst_wvalid", 64'(bus.M_AXI_WVALID), 64'(0));
    check("rst_arvalid", 64'(bus.M_AXI_ARVALID), 64'(0));
    check("rst_bready", 64'(bus.M_AXI_BREADY), 64'(0));
    check("rst_rready", 64'(bus.M_AXI_RREADY), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    check("rst_awaddr", 64'(bus.M_AXI_AWADDR), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // zero-wait write then read-back, minimum latency
    set_delays(0, 0, 0, 0, 0);
    run_txn(1, 32'h0, 32'h5, 4'hF, 0, 1);
    check("aw_w_same_cycle", 64'(t_aw), 64'(t_w));
    run_txn(0, 32'h0, 32'h0, 4'h0, 0, 1);

    // W accepted well before AW, then the reverse
    set_delays(4, 0, 1, 0, 0);
    run_txn(1, 32'h4, 32'h11223344, 4'h5, 0, 0);
    check("w_before_aw", 64'(t_w < t_aw), 64'(1));
    set_delays(0, 4, 0, 0, 0);
    run_txn(1, 32'h4, 32'hAABBCCDD, 4'hA, 0, 0);
    check("aw_before_w", 64'(t_aw < t_w), 64'(1));
    set_delays(0, 0, 0, 2, 2);
    run_txn(0, 32'h4, 32'h0, 4'h0, 0, 0);

    // error responses pass through unchanged
    set_delays(0, 0, 0, 0, 0);
    s_bresp = 2'b10;
    run_txn(1, 32'h8, 32'h12345678, 4'hF, 0, 0);
    s_bresp = 2'b00;
    s_rresp = 2'b11; s_force_en = 1; s_force_data = 32'hDEADBEEF;
    run_txn(0, 32'h8, 32'h0, 4'h0, 0, 0);
    s_rresp = 2'b00; s_force_en = 0;

    // consumer stalls the response for 5 cycles
    run_txn(1, 32'hC, 32'hCAFEF00D, 4'hF, 5, 0);
    run_txn(0, 32'hC, 32'h0, 4'h0, 5, 0);

    // reset in the middle of a write
    set_delays(8, 8, 0, 0, 0);
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 32'h0;
    bus.cmd_wdata = 32'hFFFF_FFFF; bus.cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 0;
    @(negedge clk);
    check("pre_rst_awvalid", 64'(bus.M_AXI_AWVALID), 64'(1));
    #2 rst_n = 0;
    #1;
    check("mid_rst_awvalid", 64'(bus.M_AXI_AWVALID), 64'(0));
    check("mid_rst_wvalid", 64'(bus.M_AXI_WVALID), 64'(0));
    check("mid_rst_bready", 64'(bus.M_AXI_BREADY), 64'(0));
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    set_delays(0, 0, 0, 0, 0);
    run_txn(1, 32'h0, 32'hA, 4'hF, 0, 1);
    run_txn(0, 32'h0, 32'h0, 4'h0, 0, 1);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      bit          wr;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 3)) << 2;
      set_delays(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      s_bresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s_rresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(wr, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axil_master_port.md
Name: axil_master_port

Overview:
- Synthesizable AXI4-Lite initiator for the PL. Converts single-beat commands from a local command/response handshake into AXI4-Lite write or read transactions toward slave IP such as myLED.
- One outstanding transaction at a time. Write AW/W are issued together and released independently; read data and BRESP/RRESP are returned on the local response channel.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width of cmd_addr and M_AXI_AWADDR/ARADDR.
- C_M_AXI_DATA_WIDTH, 32, data width; must be 32.

Ports:
- M_AXI_ACLK  in  1  sole clock; all logic is on the rising edge.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command (high only in IDLE).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as returned by the slave.
- rsp_was_write  out  1  echoes cmd_write of the completed transaction.
- M_AXI_AWADDR  out  ADDR_WIDTH  write address.
- M_AXI_AWPROT  out  3  tied to 3'b000.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_WDATA  out  DATA_WIDTH  write data.
- M_AXI_WSTRB  out  4  write strobes.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_ARADDR  out  ADDR_WIDTH  read address.
- M_AXI_ARPROT  out  3  tied to 3'b000.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset values (async, ARESETN low): every VALID/READY output 0 except cmd_ready=1; all address, data, strobe and rsp_* outputs 0; state IDLE.
- Reset mid-transaction aborts immediately with no response. Only an interconnect reset together with the master is supported.
- All AXI and rsp outputs are registered; no combinational path from any input to any output except cmd_ready, which is a decode of state.
- State IDLE:
  - On cmd_valid&&cmd_ready with cmd_write=1: latch addr/wdata/wstrb, drive AWVALID=WVALID=1 on the next cycle, go to WR_AW_W.
  - With cmd_write=0: drive ARVALID=1, go to RD_AR.
- State WR_AW_W:
  - AWVALID drops the cycle after AWVALID&&AWREADY; WVALID drops the cycle after WVALID&&WREADY. The two handshakes may complete in the same or different cycles, in either order.
  - A VALID is never dropped before its READY; address, data and strobe are held stable while the corresponding VALID is high.
  - When both handshakes are done (including same-cycle completion of the last), assert BREADY and go to WR_B.
- State WR_B: on BVALID&&BREADY, capture BRESP into rsp_resp, set rsp_rdata=0, rsp_was_write=1, drop BREADY, raise rsp_valid, go to RSP.
- State RD_AR: on ARVALID&&ARREADY, drop ARVALID, raise RREADY, go to RD_R.
- State RD_R: on RVALID&&RREADY, capture RDATA and RRESP, rsp_was_write=0, drop RREADY, raise rsp_valid, go to RSP.
- State RSP: hold rsp_* stable until rsp_ready. On rsp_valid&&rsp_ready, drop rsp_valid and return to IDLE, where cmd_ready=1 on the following cycle.
- BREADY/RREADY are asserted only in WR_B/RD_R. A BVALID/RVALID arriving earlier is ignored until then; AXI-Lite slaves hold it.
- Minimum latency with a zero-wait slave: write is cmd handshake to rsp_valid in 3 cycles; read is 3 cycles.
- SLVERR/DECERR are passed through unchanged and are not retried.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- Write 0x5 to 0x0 with myLED slave, strb 0xF -> AW and W accepted in the same cycle; rsp_resp=00, rsp_was_write=1; o_LED=4'h5.
- Read 0x0 after that write -> rsp_rdata=0x00000005, rsp_resp=00, rsp_was_write=0, latency 3 cycles.
- Stub slave with AWREADY 4 cycles after WREADY, then the reverse order -> WVALID drops first and AWADDR is stable throughout; exactly one BREADY pulse per write; exactly one response.
- Stub slave returns BRESP=2'b10, then RRESP=2'b11 with RDATA=0xDEADBEEF -> rsp_resp equals 10 and 11; rsp_rdata=0xDEADBEEF.
- Hold rsp_ready low for 5 cycles while cmd_valid stays high -> rsp_* stable; cmd_ready=0; no new AW/AR issued until the response is accepted.
- Deassert ARESETN while in WR_AW_W -> all VALID/READY outputs 0 immediately; cmd_ready=1 after release; the next write of 0xA completes normally.
